// File: rtl/cpu_memory_responder_if.sv
// Instruction/data memory bus plus program-loader handshake between the
// RV32I core (master) and its memory responder (slave).
interface cpu_memory_responder_if;
  logic [9:0]  instruction_address;
  logic [31:0] instruction;
  logic [9:0]  data_address;
  logic [31:0] data_out;
  logic [3:0]  width;
  logic        write_mem;
  logic [31:0] data_in;
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;

  modport master (
    output instruction_address, data_address, data_out, width, write_mem,
    output load_valid, load_addr, load_data, load_done,
    input  instruction, data_in, load_ready, cpu_hold
  );

  modport slave (
    input  instruction_address, data_address, data_out, width, write_mem,
    input  load_valid, load_addr, load_data, load_done,
    output instruction, data_in, load_ready, cpu_hold
  );
endinterface

// File: rtl/cpu_memory_responder.sv
// Instruction/data RAM responder: clears data RAM, accepts a program image,
// then serves registered fetches and byte-lane loads/stores to the core.
module cpu_memory_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_memory_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  clear_cnt_reg, clear_cnt_next;
  logic           cpu_hold_reg;
  logic [31:0]    instruction_reg;
  logic [31:0]    imem [DEPTH_WORDS];
  logic           imem_we;
  logic [3:0]     dmem_we;
  logic [AW-1:0]  dmem_waddr;
  logic [31:0]    dmem_wdata;
  logic [31:0]    data_in_word;
  logic [AW-1:0]  fetch_idx, data_idx, load_idx;
  logic           unused_addr_bits;

  assign fetch_idx = bus.instruction_address[AW+1:2];
  assign data_idx  = bus.data_address[AW+1:2];
  assign load_idx  = bus.load_addr[AW-1:0];
  assign unused_addr_bits = ^{bus.instruction_address[1:0], bus.data_address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clear_cnt_reg <= '0;
      cpu_hold_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
      cpu_hold_reg  <= (state_next != RUN);
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    imem_we        = 1'b0;
    dmem_we        = 4'h0;
    dmem_waddr     = data_idx;
    dmem_wdata     = bus.data_out;
    case (state_reg)
      CLEAR: begin
        dmem_we        = 4'hF;
        dmem_waddr     = clear_cnt_reg;
        dmem_wdata     = CLEAR_VALUE;
        clear_cnt_next = clear_cnt_reg + AW'(1);
        if (clear_cnt_reg == AW'(DEPTH_WORDS - 1))
          state_next = LOAD;
      end
      LOAD: begin
        imem_we = bus.load_valid;
        if (bus.load_done)
          state_next = RUN;
      end
      RUN: begin
        if (bus.write_mem)
          dmem_we = bus.width;
      end
      default: state_next = CLEAR;
    endcase
    // Reset must not leak a write into either RAM on its own edge.
    if (rst) begin
      imem_we = 1'b0;
      dmem_we = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we)
      imem[load_idx] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (rst || state_reg != RUN)
      instruction_reg <= NOP_WORD;
    else
      instruction_reg <= imem[fetch_idx];
  end

  // One byte-wide RAM per lane; in RUN the write and read address coincide,
  // so forwarding the written byte gives write-first merged words.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] dmem_lane [DEPTH_WORDS];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (dmem_we[gi])
          dmem_lane[dmem_waddr] <= dmem_wdata[8*gi +: 8];
      end

      always_ff @(posedge clk) begin
        if (rst || state_reg != RUN)
          rd_lane_reg <= 8'h00;
        else if (dmem_we[gi])
          rd_lane_reg <= dmem_wdata[8*gi +: 8];
        else
          rd_lane_reg <= dmem_lane[data_idx];
      end

      assign data_in_word[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

  assign bus.instruction = instruction_reg;
  assign bus.data_in     = data_in_word;
  assign bus.load_ready  = (state_reg == LOAD);
  assign bus.cpu_hold    = cpu_hold_reg;
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench for cpu_memory_responder: stimulus queues expected values
// with a due cycle; a negedge monitor compares them against the DUT outputs.
module tb_cpu_memory_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int K_INSTR = 0, K_DATA = 1, K_HOLD = 2, K_READY = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  cpu_memory_responder_if bus ();

  cpu_memory_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] actual(int k);
    case (k)
      K_INSTR: return bus.instruction;
      K_DATA:  return bus.data_in;
      K_HOLD:  return {31'b0, bus.cpu_hold};
      default: return {31'b0, bus.load_ready};
    endcase
  endfunction

  task automatic expect_at(int k, logic [31:0] e, int d, string n);
    sb_t s;
    s.due = d; s.kind = k; s.exp = e; s.name = n;
    sb.push_back(s);
  endtask

  task automatic check_val(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h required %08h", n, got, exp);
    end else
      $display("ok   %s: %08h", n, got);
  endtask

  // Monitor: compare every scoreboard entry whose due cycle has arrived.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check_val(sb[i].name, actual(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(string tag);
    expect_at(K_INSTR, NOP,   cyc, {tag, "_instr"});
    expect_at(K_DATA,  32'h0, cyc, {tag, "_data_in"});
    expect_at(K_READY, 32'h0, cyc, {tag, "_load_ready"});
    expect_at(K_HOLD,  32'h1, cyc, {tag, "_cpu_hold"});
  endtask

  // Counts edges from the end of reset until load_ready rises.
  task automatic wait_load_ready(string tag);
    int n;
    n = 0;
    while (n < 1000) begin
      tick();
      n++;
      if (bus.load_ready) break;
      expect_at(K_HOLD,  32'h1, cyc, {tag, "_clear_hold"});
      expect_at(K_INSTR, NOP,   cyc, {tag, "_clear_instr"});
    end
    check_val({tag, "_clear_cycles"}, n, 256);
  endtask

  task automatic load_word(logic [7:0] a, logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic fetch(logic [9:0] a, logic [31:0] e);
    bus.instruction_address = a;
    expect_at(K_INSTR, e, cyc + 1, $sformatf("fetch_%03h", a));
    tick();
  endtask

  task automatic data_op(logic [9:0] a, logic wr, logic [31:0] d, logic [3:0] w,
                         logic [31:0] e);
    bus.data_address = a;
    bus.write_mem    = wr;
    bus.data_out     = d;
    bus.width        = w;
    expect_at(K_DATA, e, cyc + 1, $sformatf("data_%03h_w%0d%h", a, wr, w));
    tick();
    bus.write_mem = 1'b0;
  endtask

  initial begin
    bus.instruction_address = '0;
    bus.data_address = '0;
    bus.data_out     = '0;
    bus.width        = '0;
    bus.write_mem    = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_addr    = '0;
    bus.load_data    = '0;
    bus.load_done    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst0");
    wait_load_ready("boot");

    // LOAD: store from core must be ignored; repeated address, last wins.
    expect_at(K_READY, 32'h1, cyc, "load_ready_in_load");
    bus.write_mem = 1'b1; bus.data_address = 10'h030;
    bus.data_out = 32'h1234_5678; bus.width = 4'hF;
    load_word(8'd0, 32'h0050_0093);
    bus.write_mem = 1'b0;
    load_word(8'd1, 32'h0010_8133);
    load_word(8'd2, 32'h1111_1111);
    load_word(8'd2, 32'h2222_2222);
    bus.load_done = 1'b1;
    expect_at(K_HOLD,  32'h0, cyc + 1, "hold_falls_on_done");
    expect_at(K_INSTR, NOP,   cyc + 1, "instr_nop_on_run_entry");
    load_word(8'd3, 32'h3333_3333);
    bus.load_done = 1'b0;
    expect_at(K_READY, 32'h0, cyc, "load_ready_in_run");

    fetch(10'h000, 32'h0050_0093);
    fetch(10'h004, 32'h0010_8133);
    fetch(10'h008, 32'h2222_2222);
    fetch(10'h00C, 32'h3333_3333);
    fetch(10'h007, 32'h0010_8133);

    for (int i = 0; i < 256; i++)
      data_op(10'(i * 4), 1'b0, 32'h0, 4'h0, 32'h0);

    data_op(10'h010, 1'b1, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD);
    data_op(10'h010, 1'b1, 32'h1122_3344, 4'b0010, 32'hAABB_33DD);
    data_op(10'h010, 1'b0, 32'h0,         4'b0000, 32'hAABB_33DD);
    data_op(10'h010, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'hAABB_33DD);
    data_op(10'h013, 1'b1, 32'h0000_00EE, 4'b0001, 32'hAABB_33EE);
    data_op(10'h010, 1'b0, 32'h0,         4'b0000, 32'hAABB_33EE);
    data_op(10'h020, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    data_op(10'h020, 1'b1, 32'h5566_7788, 4'b1000, 32'h55AD_BEEF);
    data_op(10'h020, 1'b0, 32'h0,         4'b0000, 32'h55AD_BEEF);
    data_op(10'h030, 1'b0, 32'h0,         4'b0000, 32'h0000_0000);

    // Reset from RUN, then again mid-LOAD after three transfers.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_run");
    wait_load_ready("reload");
    load_word(8'd10, 32'hAAAA_0001);
    load_word(8'd11, 32'hAAAA_0002);
    load_word(8'd12, 32'hAAAA_0003);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_load");
    wait_load_ready("after_load_rst");
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    expect_at(K_HOLD, 32'h0, cyc, "hold_after_second_done");

    fetch(10'h004, 32'h0010_8133);
    fetch(10'h028, 32'hAAAA_0001);
    fetch(10'h02C, 32'hAAAA_0002);
    fetch(10'h030, 32'hAAAA_0003);
    data_op(10'h010, 1'b0, 32'h0, 4'h0, 32'h0);
    data_op(10'h020, 1'b0, 32'h0, 4'h0, 32'h0);

    repeat (3) tick();
    check_val("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
